// File: rtl/neo_c1_dtack.sv
// neo_c1_dtack: 68k DTACK generator with per-zone wait states, external acknowledge and bus-error watchdog.
// Ports:
//   CLK_68KCLK  68k clock; all state updates on the rising edge
//   nRESET      asynchronous active-low reset
//   nAS         68k address strobe, active low
//   nZONE       decoded zone selects, active low; the lowest-index low zone wins
//   WAIT_CFG    per-zone wait count, zone i at [i*WAIT_W +: WAIT_W]
//   nEXTWAIT    per-zone external wait hold, active low
//   PDTACK      external acknowledge for EXT_MASK zones, active high
//   nDTACK      registered data acknowledge, active low
//   nBERR       registered bus error, active low
//   BUSY        high while a bus cycle is in progress
// Build option: define NEO_C1_BERR_EN to include the watchdog and bus-error state.
// Without it, nBERR stays high and stalled or unmapped cycles hang until nAS rises.
module neo_c1_dtack #(
  parameter int               ZONES    = 4,
  parameter int               WAIT_W   = 3,
  parameter logic [ZONES-1:0] EXT_MASK = '0,
  parameter int               TIMEOUT  = 64
) (
  input  logic                    CLK_68KCLK,
  input  logic                    nRESET,
  input  logic                    nAS,
  input  logic [ZONES-1:0]        nZONE,
  input  logic [ZONES*WAIT_W-1:0] WAIT_CFG,
  input  logic [ZONES-1:0]        nEXTWAIT,
  input  logic                    PDTACK,
  output logic                    nDTACK,
  output logic                    nBERR,
  output logic                    BUSY
);
  localparam int ZW = ZONES > 1 ? $clog2(ZONES) : 1;
  if (ZONES < 1 || ZONES > 8 || TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_param
    $error("neo_c1_dtack: ZONES or TIMEOUT out of range");
  end
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EXT, S_ACK, S_ERR} state_t;
  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ZW-1:0]     zone_q, zone_d;
  logic              ndtack_q, ndtack_d;
  logic              nberr_q, nberr_d;
  logic [ZW-1:0]     sel;
  logic [WAIT_W-1:0] sel_cfg;
  logic              sel_ext;
  logic              timeout;
  // Descending scan so the lowest-index selected zone is the one left standing.
  always_comb begin
    sel     = '0;
    sel_cfg = '0;
    sel_ext = 1'b0;
    for (int i = ZONES - 1; i >= 0; i--)
      if (!nZONE[i]) begin
        sel     = ZW'(i);
        sel_cfg = WAIT_CFG[i*WAIT_W +: WAIT_W];
        sel_ext = EXT_MASK[i];
      end
  end
`ifdef NEO_C1_BERR_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            counting;
  // The watchdog stops once the cycle is acknowledged or errored, and saturates at the limit.
  always_comb begin
    counting = !nAS && state_q != S_ACK && state_q != S_ERR;
    timeout  = counting && wd_q == WD_W'(TIMEOUT);
    wd_d     = nAS ? '0 : (counting && wd_q != WD_W'(TIMEOUT)) ? wd_q + 1'b1 : wd_q;
  end
  always_ff @(posedge CLK_68KCLK or negedge nRESET)
    if (!nRESET) wd_q <= '0;
    else         wd_q <= wd_d;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge CLK_68KCLK or negedge nRESET)
    if (!nRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      zone_q   <= '0;
      ndtack_q <= 1'b1;
      nberr_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      zone_q   <= zone_d;
      ndtack_q <= ndtack_d;
      nberr_q  <= nberr_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zone_d  = zone_q;
    case (state_q)
      S_IDLE:
        if (!nAS && !(&nZONE)) begin
          zone_d  = sel;
          cnt_d   = sel_cfg;
          state_d = sel_ext ? S_EXT : (sel_cfg == '0) ? S_ACK : S_WAIT;
        end
      S_WAIT:
        if (nAS)                         state_d = S_IDLE;
        else if (cnt_q > WAIT_W'(1))     cnt_d   = cnt_q - 1'b1;
        else if (nEXTWAIT[zone_q])       state_d = S_ACK;
      S_EXT:   state_d = nAS ? S_IDLE : PDTACK ? S_ACK : S_EXT;
      S_ACK:   state_d = nAS ? S_IDLE : S_ACK;
      S_ERR:   state_d = nAS ? S_IDLE : S_ERR;
      default: state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_ERR;
  end
  // nDTACK is held only while the cycle stays in ACK, so it releases on the same edge nAS rises.
  always_comb begin
    ndtack_d = !(state_q == S_ACK && state_d == S_ACK);
    nberr_d  = state_d != S_ERR;
  end
  assign nDTACK = ndtack_q;
  assign nBERR  = nberr_q;
  assign BUSY   = state_q != S_IDLE;
endmodule

// File: tb/tb_neo_c1_dtack.sv
// tb_neo_c1_dtack: table-driven and randomized self-checking bench for neo_c1_dtack.
module tb_neo_c1_dtack;
`ifdef NEO_C1_BERR_EN
  localparam bit BERR = 1'b1;
`else
  localparam bit BERR = 1'b0;
`endif
  localparam logic [3:0] EXT = 4'b1000;
  localparam int NF = 999;
  localparam int NEVER = 100000;
  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic        nAS = 1'b1;
  logic [3:0]  nZONE = 4'hF;
  logic [11:0] WAIT_CFG = '0;
  logic [3:0]  nEXTWAIT = 4'hF;
  logic        PDTACK = 1'b0;
  logic        nDTACK, nBERR, BUSY;
  int checks = 0;
  int failures = 0;
  neo_c1_dtack #(.ZONES(4), .WAIT_W(3), .EXT_MASK(EXT), .TIMEOUT(64)) dut (
    .CLK_68KCLK(clk), .nRESET(nRESET), .nAS(nAS), .nZONE(nZONE), .WAIT_CFG(WAIT_CFG),
    .nEXTWAIT(nEXTWAIT), .PDTACK(PDTACK), .nDTACK(nDTACK), .nBERR(nBERR), .BUSY(BUSY));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [3:0]  nz;
    logic [11:0] wc;
    int          s, p, l;
    int          dt_f, dt_l, be_f, be_l;
    int          nb_dt_f, nb_dt_l;
  } vec_t;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask
  // Closed-form expectation: the edge at which the cycle would be acknowledged
  // (max of wait count and stall release, or first PDTACK edge after capture)
  // races the watchdog limit; outputs follow one edge later for nDTACK.
  function automatic void model(input logic [3:0] nz, input logic [11:0] wc, input int s, p, l,
                                output int dt_f, dt_l, be_f, be_l);
    int z, w, ack_e, err_e;
    z = -1;
    for (int i = 3; i >= 0; i--) if (!nz[i]) z = i;
    ack_e = NEVER;
    if (z >= 0 && EXT[z]) ack_e = p > 1 ? p : 1;
    else if (z >= 0) begin
      w = int'(wc[z*3 +: 3]);
      ack_e = w == 0 ? 0 : (s > w ? s : w);
    end
    err_e = BERR ? 64 : NEVER;
    dt_f = NF; dt_l = -1; be_f = NF; be_l = -1;
    if (ack_e < err_e && ack_e < l) begin dt_f = ack_e + 1; dt_l = l - 1; end
    if (err_e <= ack_e && err_e < l) begin be_f = err_e; be_l = l - 1; end
  endfunction
  // nAS is low for edges 0..l-1; nZONE/WAIT_CFG are scrambled after the capture edge.
  task automatic run_txn(input string nm, input logic [3:0] nz, input logic [11:0] wc, input int s, p, l,
                         input int dt_f, dt_l, be_f, be_l);
    int z;
    z = -1;
    for (int i = 3; i >= 0; i--) if (!nz[i]) z = i;
    for (int k = 0; k <= l + 1; k++) begin
      nAS      = k < l ? 1'b0 : 1'b1;
      nZONE    = (k == 0 || z < 0) ? nz : 4'($urandom);
      WAIT_CFG = k == 0 ? wc : 12'($urandom);
      nEXTWAIT = 4'($urandom);
      if (z >= 0) nEXTWAIT[z] = k >= s;
      PDTACK   = k >= p;
      step();
      chk($sformatf("%s_dtack_e%0d", nm, k), nDTACK, !(k >= dt_f && k <= dt_l));
      chk($sformatf("%s_berr_e%0d", nm, k), nBERR, !(k >= be_f && k <= be_l));
      chk($sformatf("%s_busy_e%0d", nm, k), BUSY, z >= 0 && k < l);
      chk($sformatf("%s_excl_e%0d", nm, k), nDTACK | nBERR, 1'b1);
    end
  endtask
  initial begin
    vec_t vecs[$];
    int dt_f, dt_l, be_f, be_l, s, p, l;
    logic [3:0] nz;
    logic [11:0] wc;
    vecs = '{
      '{"req031",      4'b1101, {3'd0,3'd0,3'd3,3'd0}, 0,  NF, 7,  4,  6,  NF, -1, 4,  6},
      '{"req032",      4'b1100, {3'd0,3'd0,3'd5,3'd0}, 0,  NF, 4,  1,  3,  NF, -1, 1,  3},
      '{"req033",      4'b1011, {3'd0,3'd2,3'd0,3'd0}, 6,  NF, 10, 7,  9,  NF, -1, 7,  9},
      '{"req034_ext",  4'b0111, 12'd0,                 0,  5,  9,  6,  8,  NF, -1, 6,  8},
      '{"req036",      4'b1110, {3'd0,3'd0,3'd0,3'd5}, 0,  NF, 2,  NF, -1, NF, -1, NF, -1},
      '{"w1",          4'b1101, {3'd0,3'd0,3'd1,3'd0}, 0,  NF, 4,  2,  3,  NF, -1, 2,  3},
      '{"w7",          4'b1110, {3'd0,3'd0,3'd0,3'd7}, 0,  NF, 10, 8,  9,  NF, -1, 8,  9},
      '{"w1_stall",    4'b1101, {3'd0,3'd0,3'd1,3'd0}, 3,  NF, 6,  4,  5,  NF, -1, 4,  5},
      '{"ext_early",   4'b0111, 12'd0,                 0,  0,  4,  2,  3,  NF, -1, 2,  3},
      '{"ext_abort",   4'b0111, 12'd0,                 0,  NF, 3,  NF, -1, NF, -1, NF, -1},
      '{"zone_pri",    4'b1000, {3'd7,3'd7,3'd7,3'd2}, 0,  NF, 5,  3,  4,  NF, -1, 3,  4},
      '{"ext_timeout", 4'b0111, 12'd0,                 0,  NF, 68, NF, -1, 64, 67, NF, -1},
      '{"unmapped",    4'b1111, 12'd0,                 0,  NF, 67, NF, -1, 64, 66, NF, -1},
      '{"ack63",       4'b1110, {3'd0,3'd0,3'd0,3'd7}, 63, NF, 70, 64, 69, NF, -1, 64, 69},
      '{"ack64",       4'b1110, {3'd0,3'd0,3'd0,3'd7}, 64, NF, 70, NF, -1, 64, 69, 65, 69}
    };
    step();
    chk("reset_dtack", nDTACK, 1'b1);
    chk("reset_berr", nBERR, 1'b1);
    chk("reset_busy", BUSY, 1'b0);
    nRESET = 1'b1;
    step();
    foreach (vecs[i])
      run_txn(vecs[i].name, vecs[i].nz, vecs[i].wc, vecs[i].s, vecs[i].p, vecs[i].l,
              BERR ? vecs[i].dt_f : vecs[i].nb_dt_f, BERR ? vecs[i].dt_l : vecs[i].nb_dt_l,
              BERR ? vecs[i].be_f : NF, BERR ? vecs[i].be_l : -1);
    for (int t = 0; t < 60; t++) begin
      nz = 4'($urandom);
      wc = 12'($urandom);
      s  = $urandom_range(0, 10);
      p  = ($urandom_range(0, 3) == 0) ? NF : $urandom_range(0, 15);
      l  = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 72) : $urandom_range(1, 20);
      model(nz, wc, s, p, l, dt_f, dt_l, be_f, be_l);
      run_txn($sformatf("rnd%0d", t), nz, wc, s, p, l, dt_f, dt_l, be_f, be_l);
    end
    // Reset while acknowledging, then release with nAS still low: captured on the first edge.
    nAS = 1'b0; nZONE = 4'b1110; WAIT_CFG = '0; nEXTWAIT = 4'hF; PDTACK = 1'b0;
    step();
    chk("mid_capture_busy", BUSY, 1'b1);
    step();
    chk("mid_ack_dtack", nDTACK, 1'b0);
    nRESET = 1'b0;
    #1;
    chk("mid_reset_dtack", nDTACK, 1'b1);
    chk("mid_reset_busy", BUSY, 1'b0);
    chk("mid_reset_berr", nBERR, 1'b1);
    #1 nRESET = 1'b1;
    step();
    chk("rel_capture_busy", BUSY, 1'b1);
    chk("rel_capture_dtack", nDTACK, 1'b1);
    step();
    chk("rel_ack_dtack", nDTACK, 1'b0);
    nAS = 1'b1;
    step();
    chk("rel_end_dtack", nDTACK, 1'b1);
    chk("rel_end_busy", BUSY, 1'b0);
    // Unmapped access with a reset pulse at edge 30: the watchdog restarts from zero.
    nAS = 1'b0; nZONE = 4'hF;
    for (int k = 0; k <= 30; k++) step();
    chk("wd30_berr", nBERR, 1'b1);
    nRESET = 1'b0;
    #1;
    chk("wd_reset_berr", nBERR, 1'b1);
    chk("wd_reset_dtack", nDTACK, 1'b1);
    #1 nRESET = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      step();
      if (k == 63) chk("wd_restart_e63_berr", nBERR, 1'b1);
      if (k == 64) chk("wd_restart_e64_berr", nBERR, !BERR);
    end
    chk("wd_err_dtack", nDTACK, 1'b1);
    nRESET = 1'b0;
    #1;
    chk("err_reset_berr", nBERR, 1'b1);
    chk("err_reset_busy", BUSY, 1'b0);
    #1 nRESET = 1'b1;
    nAS = 1'b1;
    step();
    chk("final_berr", nBERR, 1'b1);
    chk("final_busy", BUSY, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
